// File: rtl/argmax_stream.sv
// Streaming signed extremum finder: tracks the max (or min) value of a handshaked
// frame together with its tag and presents value, tag and frame length once the frame ends.
module argmax_stream #(
  parameter  int NUM_W    = 8,
  parameter  int AD_W     = 8,
  parameter  int MAX_LEN  = 16,
  parameter  int FIND_MIN = 0,
  localparam int CNT_W    = $clog2(MAX_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [NUM_W-1:0] in_num,
  input  logic [AD_W-1:0]         in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [NUM_W-1:0] out_num,
  output logic [AD_W-1:0]         out_data,
  output logic [CNT_W-1:0]        out_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic signed [NUM_W-1:0] best_num_r, best_num_nxt_s;
  logic [AD_W-1:0]         best_data_r, best_data_nxt_s;
  logic [CNT_W-1:0]        cnt_r, cnt_nxt_s, cnt_inc_s;
  logic                    accept_s;
  logic                    load_out_s;
  logic signed [NUM_W-1:0] out_num_r;
  logic [AD_W-1:0]         out_data_r;
  logic [CNT_W-1:0]        out_count_r;

  // Strict comparison so that ties keep the earlier element (first occurrence wins).
  function automatic logic beats_best(input logic signed [NUM_W-1:0] cand,
                                      input logic signed [NUM_W-1:0] best);
    if (FIND_MIN != 0) begin
      return cand < best;
    end else begin
      return cand > best;
    end
  endfunction

  assign in_ready  = (state_r != ST_DONE);
  assign out_valid = (state_r == ST_DONE);
  assign out_num   = out_num_r;
  assign out_data  = out_data_r;
  assign out_count = out_count_r;

  assign accept_s  = in_valid && (state_r != ST_DONE) && !clr;
  assign cnt_inc_s = cnt_r + CNT_W'(1);

  // Next-state, running-extremum and beat-count logic.
  always_comb begin
    state_nxt_s     = state_r;
    best_num_nxt_s  = best_num_r;
    best_data_nxt_s = best_data_r;
    cnt_nxt_s       = cnt_r;
    load_out_s      = 1'b0;
    if (clr) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            best_num_nxt_s  = in_num;
            best_data_nxt_s = in_data;
            cnt_nxt_s       = CNT_W'(1);
            if (in_last || (MAX_LEN == 1)) begin
              state_nxt_s = ST_DONE;
              load_out_s  = 1'b1;
            end else begin
              state_nxt_s = ST_ACC;
            end
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_ACC: begin
          if (accept_s) begin
            cnt_nxt_s = cnt_inc_s;
            if (beats_best(in_num, best_num_r)) begin
              best_num_nxt_s  = in_num;
              best_data_nxt_s = in_data;
            end else begin
              best_num_nxt_s  = best_num_r;
              best_data_nxt_s = best_data_r;
            end
            // A full frame ends on its own; in_last on that beat is irrelevant.
            if (in_last || (cnt_inc_s == CNT_W'(MAX_LEN))) begin
              state_nxt_s = ST_DONE;
              load_out_s  = 1'b1;
            end else begin
              state_nxt_s = ST_ACC;
            end
          end else begin
            state_nxt_s = ST_ACC;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = {CNT_W{1'b0}};
          end else begin
            state_nxt_s = ST_DONE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      best_num_r  <= {NUM_W{1'b0}};
      best_data_r <= {AD_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      best_num_r  <= best_num_nxt_s;
      best_data_r <= best_data_nxt_s;
      cnt_r       <= cnt_nxt_s;
    end
  end

  // Result registers: captured once per frame so they stay stable throughout DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_num_r   <= {NUM_W{1'b0}};
      out_data_r  <= {AD_W{1'b0}};
      out_count_r <= {CNT_W{1'b0}};
    end else if (load_out_s) begin
      out_num_r   <= best_num_nxt_s;
      out_data_r  <= best_data_nxt_s;
      out_count_r <= cnt_nxt_s;
    end else begin
      out_num_r   <= out_num_r;
      out_data_r  <= out_data_r;
      out_count_r <= out_count_r;
    end
  end

endmodule

// File: tb/tb_argmax_stream.sv
// Directed bench for argmax_stream: a max finder, a min finder and a MAX_LEN=4 max finder
// share the data inputs; each has its own in_valid so frames can target one or several.
module tb_argmax_stream;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clr;
  logic              out_ready;
  logic [2:0]        iv;
  logic signed [7:0] in_num;
  logic [7:0]        in_data;
  logic              in_last;

  logic              ir0, ir1, ir2, ov0, ov1, ov2;
  logic signed [7:0] on0, on1, on2;
  logic [7:0]        od0, od1, od2;
  logic [4:0]        oc0, oc1;
  logic [2:0]        oc2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  argmax_stream #(.NUM_W(8), .AD_W(8), .MAX_LEN(16), .FIND_MIN(0)) u_max (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(iv[0]), .in_ready(ir0),
    .in_num(in_num), .in_data(in_data), .in_last(in_last), .out_valid(ov0),
    .out_ready(out_ready), .out_num(on0), .out_data(od0), .out_count(oc0));

  argmax_stream #(.NUM_W(8), .AD_W(8), .MAX_LEN(16), .FIND_MIN(1)) u_min (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(iv[1]), .in_ready(ir1),
    .in_num(in_num), .in_data(in_data), .in_last(in_last), .out_valid(ov1),
    .out_ready(out_ready), .out_num(on1), .out_data(od1), .out_count(oc1));

  argmax_stream #(.NUM_W(8), .AD_W(8), .MAX_LEN(4), .FIND_MIN(0)) u_len4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(iv[2]), .in_ready(ir2),
    .in_num(in_num), .in_data(in_data), .in_last(in_last), .out_valid(ov2),
    .out_ready(out_ready), .out_num(on2), .out_data(od2), .out_count(oc2));

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents one beat from a negedge, returns at the following negedge.
  task automatic beat(input logic [2:0] m, input int n, input int d, input logic l);
    iv      = m;
    in_num  = n[7:0];
    in_data = d[7:0];
    in_last = l;
    @(negedge clk);
    iv      = 3'b000;
    in_last = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; out_ready = 1'b0;
    iv = 3'b000; in_num = 8'sd0; in_data = 8'd0; in_last = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", int'(ir0), 1);
    check("rst_valid", int'(ov0), 0);
    check("rst_num",   int'(on0), 0);
    check("rst_cnt",   int'(oc0), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Max with a tie: {3,-5,7,2,7}
    beat(3'b001, 3, 0, 1'b0);
    beat(3'b001, -5, 1, 1'b0);
    beat(3'b001, 7, 2, 1'b0);
    beat(3'b001, 2, 3, 1'b0);
    check("t1_valid_early", int'(ov0), 0);
    beat(3'b001, 7, 4, 1'b1);
    check("t1_valid", int'(ov0), 1);
    check("t1_num",   int'(on0), 7);
    check("t1_data",  int'(od0), 2);
    check("t1_cnt",   int'(oc0), 5);
    check("t1_ready", int'(ir0), 0);
    release_result();
    check("t1_valid_off", int'(ov0), 0);
    check("t1_ready_on",  int'(ir0), 1);

    // Signed extremes, max and min side by side
    beat(3'b011, -128, 0, 1'b0);
    beat(3'b011, -1, 1, 1'b0);
    beat(3'b011, -128, 2, 1'b1);
    check("t2_max_num",  int'(on0), -1);
    check("t2_max_data", int'(od0), 1);
    check("t2_max_cnt",  int'(oc0), 3);
    check("t2_min_valid", int'(ov1), 1);
    check("t2_min_num",  int'(on1), -128);
    check("t2_min_data", int'(od1), 0);
    release_result();
    check("t2_min_valid_off", int'(ov1), 0);

    // Forced frame end at MAX_LEN=4, then backpressure with a beat waiting
    beat(3'b100, 1, 10, 1'b0);
    beat(3'b100, 5, 11, 1'b0);
    beat(3'b100, -3, 12, 1'b0);
    beat(3'b100, 2, 13, 1'b0);
    check("t3_valid", int'(ov2), 1);
    check("t3_num",   int'(on2), 5);
    check("t3_data",  int'(od2), 11);
    check("t3_cnt",   int'(oc2), 4);
    iv = 3'b100; in_num = 8'sd9; in_data = 8'd14; in_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_hold_valid", int'(ov2), 1);
      check("t3_hold_num",   int'(on2), 5);
      check("t3_hold_ready", int'(ir2), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("t3_rel_valid", int'(ov2), 0);
    check("t3_rel_ready", int'(ir2), 1);
    @(negedge clk);
    iv = 3'b000;
    check("t3_acc_valid", int'(ov2), 0);
    beat(3'b100, 4, 15, 1'b1);
    check("t3_f2_num",  int'(on2), 9);
    check("t3_f2_data", int'(od2), 14);
    check("t3_f2_cnt",  int'(oc2), 2);
    release_result();

    // clr alongside beat 4 drops the frame and the beat
    beat(3'b001, 1, 1, 1'b0);
    beat(3'b001, 2, 2, 1'b0);
    beat(3'b001, 3, 3, 1'b0);
    clr = 1'b1;
    beat(3'b001, 100, 8'h77, 1'b1);
    clr = 1'b0;
    check("t4_valid", int'(ov0), 0);
    check("t4_ready", int'(ir0), 1);
    @(negedge clk);
    check("t4_valid2", int'(ov0), 0);
    beat(3'b001, -9, 8'h55, 1'b1);
    check("t4_valid3", int'(ov0), 1);
    check("t4_num",    int'(on0), -9);
    check("t4_data",   int'(od0), 8'h55);
    check("t4_cnt",    int'(oc0), 1);
    release_result();

    // Asynchronous reset between edges in the middle of a frame
    beat(3'b001, 20, 1, 1'b0);
    beat(3'b001, 30, 2, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_valid", int'(ov0), 0);
    check("t5_ready", int'(ir0), 1);
    check("t5_num",   int'(on0), 0);
    check("t5_data",  int'(od0), 0);
    check("t5_cnt",   int'(oc0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_no_valid", int'(ov0), 0);
    end
    beat(3'b001, 42, 9, 1'b1);
    check("t5_new_valid", int'(ov0), 1);
    check("t5_new_num",   int'(on0), 42);
    check("t5_new_cnt",   int'(oc0), 1);
    release_result();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
